// File: rtl/vx_exec_commit_arb_pkg.sv
// Shared types and width helpers for the execute-stage commit merger.
package vx_exec_commit_arb_pkg;

  localparam int unsigned DefaultDataW = 64;

  // Commit packet as seen at the merged commit port (default width).
  typedef logic [DefaultDataW-1:0] commit_pkt_t;

  // Unit index width, at least one bit even for a single unit.
  function automatic int unsigned calc_unitw(int unsigned num_units);
    return (num_units > 1) ? $clog2(num_units) : 1;
  endfunction

  // Counter width able to hold 0..max_inflight inclusive.
  function automatic int unsigned calc_cntw(int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/vx_commit_skid_fifo.sv
// Per-unit commit buffer: small circular FIFO, no empty bypass.
module vx_commit_skid_fifo
  import vx_exec_commit_arb_pkg::*;
#(
  parameter int unsigned DATAW     = 64,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             empty_next_o
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic [DATAW-1:0] mem_q [BUF_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Occupancy flags, handshakes and next-state pointers; pointers wrap naturally.
  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CntW'(BUF_DEPTH));
    do_pop   = pop_i && !empty_o;
    // A full buffer may still accept when the head leaves in the same cycle.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    empty_next_o = (count_d == '0);
    data_o       = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vx_exec_commit_arb.sv
// Execute-stage commit merger: per-unit skid buffers, round-robin merge into
// one registered commit port, and per-unit in-flight tracking that throttles
// dispatch credit.
module vx_exec_commit_arb
  import vx_exec_commit_arb_pkg::*;
#(
  parameter int unsigned NUM_UNITS    = 4,
  parameter int unsigned DATAW        = 64,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned MAX_INFLIGHT = 8,
  localparam int unsigned UNITW       = calc_unitw(NUM_UNITS),
  localparam int unsigned CNTW        = calc_cntw(MAX_INFLIGHT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        disp_valid_in,
  output logic [NUM_UNITS-1:0]        disp_ready_out,
  input  logic [NUM_UNITS-1:0]        unit_commit_valid_in,
  input  logic [NUM_UNITS*DATAW-1:0]  unit_commit_data_in,
  output logic [NUM_UNITS-1:0]        unit_commit_ready_out,
  output logic                        commit_valid_out,
  output logic [DATAW-1:0]            commit_data_out,
  output logic [UNITW-1:0]            commit_unit_out,
  input  logic                        commit_ready_in,
  output logic [NUM_UNITS*CNTW-1:0]   inflight_out,
  output logic                        idle_out
);

  logic [NUM_UNITS-1:0] buf_push, buf_pop, buf_empty, buf_full, buf_empty_next;
  logic [DATAW-1:0]     buf_data [NUM_UNITS];
  logic [NUM_UNITS-1:0] disp_fire, out_fire;
  logic [CNTW-1:0]      cnt_q [NUM_UNITS];
  logic [CNTW-1:0]      cnt_d [NUM_UNITS];
  logic [UNITW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAW-1:0]     out_data_q, out_data_d;
  logic [UNITW-1:0]     out_unit_q, out_unit_d;
  logic                 idle_q, idle_d;
  logic                 arb_en, win_found;
  logic [UNITW-1:0]     win_idx;
  logic [DATAW-1:0]     win_data;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    vx_commit_skid_fifo #(
      .DATAW     (DATAW),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (buf_push[u]),
      .pop_i        (buf_pop[u]),
      .data_i       (unit_commit_data_in[u*DATAW +: DATAW]),
      .data_o       (buf_data[u]),
      .empty_o      (buf_empty[u]),
      .full_o       (buf_full[u]),
      .empty_next_o (buf_empty_next[u])
    );
  end

  // Per-unit handshakes; both credit outputs are forced low while in reset.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_commit_ready_out[u] = !reset && !buf_full[u];
      buf_push[u]              = unit_commit_valid_in[u] && unit_commit_ready_out[u];
      disp_ready_out[u]        = !reset && (cnt_q[u] < CNTW'(MAX_INFLIGHT));
      disp_fire[u]             = disp_valid_in[u] && disp_ready_out[u];
      out_fire[u]              = out_valid_q && commit_ready_in && (out_unit_q == UNITW'(u));
    end
  end

  // Round-robin pick: first non-empty buffer at or after rr_ptr, then wrap.
  always_comb begin
    arb_en    = !out_valid_q || commit_ready_in;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!win_found && !buf_empty[u] && (u >= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = UNITW'(u);
        win_data  = buf_data[u];
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!win_found && !buf_empty[u]) begin
        win_found = 1'b1;
        win_idx   = UNITW'(u);
        win_data  = buf_data[u];
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      buf_pop[u] = arb_en && win_found && (win_idx == UNITW'(u));
    end
  end

  // Output register, pointer, counter and idle next-state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_unit_d  = out_unit_q;
    if (arb_en) begin
      if (win_found) begin
        out_valid_d = 1'b1;
        out_data_d  = win_data;
        out_unit_d  = win_idx;
        rr_ptr_d    = (32'(win_idx) == NUM_UNITS - 1) ? '0 : win_idx + UNITW'(1);
      end else begin
        // Slot drained with nothing behind it; data is left as-is.
        out_valid_d = 1'b0;
      end
    end
    idle_d = !out_valid_d;
    for (int u = 0; u < NUM_UNITS; u++) begin
      cnt_d[u] = cnt_q[u];
      if (disp_fire[u] && !out_fire[u]) begin
        cnt_d[u] = cnt_q[u] + CNTW'(1);
      end else if (!disp_fire[u] && out_fire[u] && (cnt_q[u] != '0)) begin
        cnt_d[u] = cnt_q[u] - CNTW'(1);
      end
      if ((cnt_d[u] != '0) || !buf_empty_next[u]) idle_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_unit_q  <= '0;
      idle_q      <= 1'b1;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_unit_q  <= out_unit_d;
      idle_q      <= idle_d;
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= cnt_d[u];
    end
  end

  // A commit from a unit with nothing in flight means the unit broke protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        assert (!(out_fire[u] && !disp_fire[u] && (cnt_q[u] == '0)));
      end
    end
  end

  // Drive outputs from registered state.
  always_comb begin
    commit_valid_out = out_valid_q;
    commit_data_out  = out_data_q;
    commit_unit_out  = out_unit_q;
    idle_out         = idle_q;
    inflight_out     = '0;
    for (int u = 0; u < NUM_UNITS; u++) inflight_out[u*CNTW +: CNTW] = cnt_q[u];
  end

endmodule

// File: tb/tb_vx_exec_commit_arb.sv
// Self-checking bench for vx_exec_commit_arb: queue-based reference model,
// scoreboard of merged commits, directed scenarios plus randomized traffic.
module tb_vx_exec_commit_arb;
  import vx_exec_commit_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int MAXF  = 8;
  localparam int UW    = 2;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    disp_valid_in, disp_ready_out;
  logic [N-1:0]    unit_commit_valid_in, unit_commit_ready_out;
  logic [N*DW-1:0] unit_commit_data_in;
  logic            commit_valid_out, commit_ready_in, idle_out;
  logic [DW-1:0]   commit_data_out;
  logic [UW-1:0]   commit_unit_out;
  logic [N*CW-1:0] inflight_out;

  always #5 clk = ~clk;

  vx_exec_commit_arb #(
    .NUM_UNITS    (N),
    .DATAW        (DW),
    .BUF_DEPTH    (DEPTH),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .disp_valid_in         (disp_valid_in),
    .disp_ready_out        (disp_ready_out),
    .unit_commit_valid_in  (unit_commit_valid_in),
    .unit_commit_data_in   (unit_commit_data_in),
    .unit_commit_ready_out (unit_commit_ready_out),
    .commit_valid_out      (commit_valid_out),
    .commit_data_out       (commit_data_out),
    .commit_unit_out       (commit_unit_out),
    .commit_ready_in       (commit_ready_in),
    .inflight_out          (inflight_out),
    .idle_out              (idle_out)
  );

  typedef struct {
    int          unit;
    commit_pkt_t data;
  } pkt_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: buffers as queues, counts as plain integers.
  commit_pkt_t mbuf[N][$];
  pkt_t        exp_out[$];
  bit          m_valid = 1'b0;
  commit_pkt_t m_data  = '0;
  int          m_unit  = 0;
  int          m_rr    = 0;
  int          m_cnt[N];
  int          owed[N];
  bit          m_idle  = 1'b1;
  int          fired_unit[$];
  int          fired_cyc[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model update on each active edge from the inputs the bench drives.
  always @(posedge clk) begin
    bit          of;
    int          win, uu;
    bit          dfire[N];
    bit          pfire[N];
    commit_pkt_t pd[N];
    pkt_t        p;
    cyc++;
    if (reset) begin
      for (int u = 0; u < N; u++) begin
        mbuf[u].delete();
        m_cnt[u] = 0;
        owed[u]  = 0;
      end
      exp_out.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_unit  = 0;
      m_rr    = 0;
      m_idle  = 1'b1;
    end else begin
      of = m_valid && commit_ready_in;
      for (int u = 0; u < N; u++) begin
        dfire[u] = disp_valid_in[u] && (m_cnt[u] < MAXF);
        pfire[u] = unit_commit_valid_in[u] && (mbuf[u].size() < DEPTH);
        pd[u]    = unit_commit_data_in[u*DW +: DW];
      end
      win = -1;
      if (!m_valid || commit_ready_in) begin
        for (int k = 0; k < N; k++) begin
          uu = (m_rr + k) % N;
          if (win < 0 && mbuf[uu].size() > 0) win = uu;
        end
      end
      for (int u = 0; u < N; u++) begin
        if (dfire[u]) m_cnt[u]++;
        if (of && m_unit == u) m_cnt[u]--;
        if (dfire[u]) owed[u]++;
        if (pfire[u]) owed[u]--;
      end
      if (of) m_valid = 1'b0;
      if (win >= 0) begin
        m_data  = mbuf[win].pop_front();
        m_valid = 1'b1;
        m_unit  = win;
        m_rr    = (win + 1) % N;
        p.unit  = win;
        p.data  = m_data;
        exp_out.push_back(p);
      end
      for (int u = 0; u < N; u++) if (pfire[u]) mbuf[u].push_back(pd[u]);
      m_idle = !m_valid;
      for (int u = 0; u < N; u++) if (m_cnt[u] != 0 || mbuf[u].size() != 0) m_idle = 1'b0;
    end
  end

  // Monitor: scoreboard on output fires, per-cycle status compare.
  always @(negedge clk) begin
    logic [N-1:0]    edr, eur;
    logic [N*CW-1:0] eif;
    pkt_t            e;
    if (chk_en) begin
      if (!reset && commit_valid_out && commit_ready_in) begin
        if (exp_out.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_fire: got unit %0d data 0x%0h, required no packet (cycle %0d)",
                   commit_unit_out, commit_data_out, cyc);
        end else begin
          e = exp_out.pop_front();
          chk("fire_unit", 64'(commit_unit_out), 64'(e.unit));
          chk("fire_data", commit_data_out, e.data);
        end
        fired_unit.push_back(int'(commit_unit_out));
        fired_cyc.push_back(cyc);
      end
      for (int u = 0; u < N; u++) begin
        edr[u]              = !reset && (m_cnt[u] < MAXF);
        eur[u]              = !reset && (mbuf[u].size() < DEPTH);
        eif[u*CW +: CW]     = m_cnt[u][CW-1:0];
      end
      chk("commit_valid", 64'(commit_valid_out), 64'(m_valid));
      if (m_valid) chk("commit_data_hold", commit_data_out, m_data);
      chk("disp_ready", 64'(disp_ready_out), 64'(edr));
      chk("unit_ready", 64'(unit_commit_ready_out), 64'(eur));
      chk("inflight", 64'(inflight_out), 64'(eif));
      chk("idle", 64'(idle_out), 64'(m_idle));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid_in        = '0;
    unit_commit_valid_in = '0;
    unit_commit_data_in  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_log();
    fired_unit.delete();
    fired_cyc.delete();
  endtask

  initial begin
    bit done;
    reset           = 1'b1;
    commit_ready_in = 1'b0;
    clear_inputs();
    step();
    step();
    chk_en = 1'b1;

    // Reset state (reset still high).
    chk("rst_valid", 64'(commit_valid_out), 0);
    chk("rst_data", commit_data_out, 0);
    chk("rst_unit", 64'(commit_unit_out), 0);
    chk("rst_idle", 64'(idle_out), 1);
    chk("rst_inflight", 64'(inflight_out), 0);
    chk("rst_disp_ready", 64'(disp_ready_out), 0);
    chk("rst_unit_ready", 64'(unit_commit_ready_out), 0);
    reset = 1'b0;
    step();
    chk("post_rst_disp_ready", 64'(disp_ready_out), 64'hF);
    chk("post_rst_unit_ready", 64'(unit_commit_ready_out), 64'hF);

    // Single unit 0: push in cycle N, output in N+2, count drops after fire.
    commit_ready_in = 1'b1;
    disp_valid_in   = 4'b0001;
    step();
    disp_valid_in              = '0;
    unit_commit_valid_in       = 4'b0001;
    unit_commit_data_in[63:0]  = 64'hA5;
    step();
    unit_commit_valid_in = '0;
    chk("t1_n1_valid", 64'(commit_valid_out), 0);
    step();
    chk("t1_n2_valid", 64'(commit_valid_out), 1);
    chk("t1_n2_data", commit_data_out, 64'hA5);
    chk("t1_n2_unit", 64'(commit_unit_out), 0);
    chk("t1_n2_inflight0", 64'(inflight_out[3:0]), 1);
    step();
    chk("t1_after_inflight0", 64'(inflight_out[3:0]), 0);
    chk("t1_after_valid", 64'(commit_valid_out), 0);

    // Two packets per unit, then free-running drain in round-robin order.
    do_reset();
    commit_ready_in = 1'b0;
    disp_valid_in   = '1;
    step();
    step();
    disp_valid_in = '0;
    for (int p = 0; p < 2; p++) begin
      unit_commit_valid_in = '1;
      for (int u = 0; u < N; u++) unit_commit_data_in[u*DW +: DW] = {$urandom, $urandom};
      step();
    end
    unit_commit_valid_in = '0;
    clear_log();
    commit_ready_in = 1'b1;
    repeat (10) step();
    chk("t2_fire_count", 64'(fired_unit.size()), 8);
    for (int i = 0; i < 8 && i < fired_unit.size(); i++) begin
      chk($sformatf("t2_order_%0d", i), 64'(fired_unit[i]), 64'(i % N));
      chk($sformatf("t2_back_to_back_%0d", i), 64'(fired_cyc[i] - fired_cyc[0]), 64'(i));
    end

    // Unit 2 streams into a stalled output for five cycles.
    clear_log();
    commit_ready_in = 1'b0;
    disp_valid_in   = 4'b0100;
    repeat (4) step();
    disp_valid_in        = '0;
    unit_commit_valid_in = 4'b0100;
    for (int p = 0; p < 3; p++) begin
      unit_commit_data_in[2*DW +: DW] = {$urandom, $urandom};
      step();
    end
    chk("t3_unit2_blocked", 64'(unit_commit_ready_out[2]), 0);
    step();
    chk("t3_hold_valid", 64'(commit_valid_out), 1);
    step();
    commit_ready_in = 1'b1;
    repeat (12) begin
      unit_commit_valid_in[2]         = (owed[2] > 0);
      unit_commit_data_in[2*DW +: DW] = {$urandom, $urandom};
      step();
    end
    unit_commit_valid_in = '0;
    step();
    chk("t3_fires", 64'(fired_unit.size()), 4);
    chk("t3_idle", 64'(idle_out), 1);

    // Unit 1 saturates its dispatch credit; one commit restores it.
    disp_valid_in = 4'b0010;
    repeat (9) step();
    chk("t4_ready1_low", 64'(disp_ready_out[1]), 0);
    chk("t4_inflight1", 64'(inflight_out[7:4]), 8);
    chk("t4_others_ready", 64'({disp_ready_out[3:2], disp_ready_out[0]}), 64'b111);
    unit_commit_valid_in            = 4'b0010;
    unit_commit_data_in[1*DW +: DW] = 64'h1111;
    step();
    unit_commit_valid_in = '0;
    step();
    step();
    chk("t4_ready1_restored", 64'(disp_ready_out[1]), 1);
    chk("t4_inflight1_after", 64'(inflight_out[7:4]), 7);
    disp_valid_in = '0;
    step();

    // Unit 3: dispatch and commit fire together leave the count unchanged.
    do_reset();
    commit_ready_in = 1'b1;
    disp_valid_in   = 4'b1000;
    repeat (5) step();
    disp_valid_in                   = '0;
    unit_commit_valid_in            = 4'b1000;
    unit_commit_data_in[3*DW +: DW] = 64'h3333;
    step();
    unit_commit_valid_in = '0;
    step();
    disp_valid_in = 4'b1000;
    chk("t5_valid", 64'(commit_valid_out), 1);
    chk("t5_inflight3_before", 64'(inflight_out[15:12]), 5);
    step();
    disp_valid_in = '0;
    chk("t5_inflight3_after", 64'(inflight_out[15:12]), 5);

    // Reset with packets buffered and instructions in flight.
    do_reset();
    commit_ready_in = 1'b0;
    disp_valid_in   = 4'b0001;
    repeat (4) step();
    disp_valid_in        = '0;
    unit_commit_valid_in = 4'b0001;
    for (int p = 0; p < 3; p++) begin
      unit_commit_data_in[63:0] = {$urandom, $urandom};
      step();
    end
    unit_commit_valid_in = '0;
    reset = 1'b1;
    step();
    chk("t6_valid", 64'(commit_valid_out), 0);
    chk("t6_inflight", 64'(inflight_out), 0);
    chk("t6_idle", 64'(idle_out), 1);
    reset = 1'b0;
    commit_ready_in = 1'b1;
    clear_log();
    repeat (5) step();
    chk("t6_no_stale", 64'(fired_unit.size()), 0);

    // Randomized traffic with occasional mid-stream reset.
    repeat (3000) begin
      commit_ready_in = ($urandom_range(0, 3) != 0);
      reset           = ($urandom_range(0, 999) == 0);
      for (int u = 0; u < N; u++) begin
        disp_valid_in[u]                = 1'($urandom_range(0, 1));
        unit_commit_valid_in[u]         = (owed[u] > 0) && ($urandom_range(0, 2) != 0);
        unit_commit_data_in[u*DW +: DW] = {$urandom, $urandom};
      end
      step();
    end

    // Drain everything still owed, bounded.
    reset           = 1'b0;
    disp_valid_in   = '0;
    commit_ready_in = 1'b1;
    done            = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      for (int u = 0; u < N; u++) unit_commit_valid_in[u] = (owed[u] > 0);
      step();
      done = m_idle;
    end
    unit_commit_valid_in = '0;
    step();
    chk("drain_idle", 64'(idle_out), 1);
    chk("drain_inflight", 64'(inflight_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
